// File: rtl/vid_timing_pkg.sv
// rtl/vid_timing_pkg.sv - default 640x480@60 raster timing constants and helpers
package vid_timing_pkg;

    // Default pixel divider: four pclk cycles per pixel.
    localparam int PIX_CLK_DIV_DEFAULT = 4;

    // Default horizontal timing, in pixels.
    localparam int H_RES_DEFAULT   = 640;
    localparam int H_FRONT_DEFAULT = 16;
    localparam int H_SYNC_DEFAULT  = 96;
    localparam int H_BACK_DEFAULT  = 48;

    // Default vertical timing, in lines.
    localparam int V_RES_DEFAULT   = 480;
    localparam int V_FRONT_DEFAULT = 10;
    localparam int V_SYNC_DEFAULT  = 2;
    localparam int V_BACK_DEFAULT  = 33;

    // Total positions on one axis: active + front porch + sync + back porch.
    function automatic int unsigned axis_total(
        input int unsigned res,
        input int unsigned front,
        input int unsigned sync_len,
        input int unsigned back
    );
        return res + front + sync_len + back;
    endfunction

    localparam int unsigned H_TOTAL_DEFAULT =
        axis_total(H_RES_DEFAULT, H_FRONT_DEFAULT, H_SYNC_DEFAULT, H_BACK_DEFAULT);
    localparam int unsigned V_TOTAL_DEFAULT =
        axis_total(V_RES_DEFAULT, V_FRONT_DEFAULT, V_SYNC_DEFAULT, V_BACK_DEFAULT);

endpackage

// File: rtl/vid_sync_gen_if.sv
// rtl/vid_sync_gen_if.sv - raster timing bundle between sync generator and pixel pipe
interface vid_sync_gen_if #(
    parameter int CNT_BITS = 12
);
    logic [3:0]          pc_ena;
    logic [CNT_BITS-1:0] h_count;
    logic [CNT_BITS-1:0] v_count;
    logic                hde;
    logic                vde;
    logic                hs;
    logic                vs;
    logic                line_start;
    logic                frame_start;
    logic [CNT_BITS-1:0] raster_line;
    logic                raster_irq;

    // Timing generator side: drives the raster, receives the line compare value.
    modport master (
        output pc_ena, h_count, v_count, hde, vde, hs, vs,
        output line_start, frame_start, raster_irq,
        input  raster_line
    );

    // Pixel pipe side: consumes the raster, supplies the line compare value.
    modport slave (
        input  pc_ena, h_count, v_count, hde, vde, hs, vs,
        input  line_start, frame_start, raster_irq,
        output raster_line
    );
endinterface

// File: rtl/vid_sync_gen_axis_counter.sv
// rtl/vid_sync_gen_axis_counter.sv - one raster axis: position counter with enable/sync decode
module vsg_axis_counter
    import vid_timing_pkg::*;
#(
    parameter int CNT_BITS = 12
) (
    input  logic                pclk,
    input  logic                reset,
    input  logic                step,
    input  logic [CNT_BITS-1:0] res_len,
    input  logic [CNT_BITS-1:0] front_len,
    input  logic [CNT_BITS-1:0] sync_len,
    input  logic [CNT_BITS-1:0] back_len,
    output logic [CNT_BITS-1:0] count,
    output logic                de,
    output logic                sync,
    output logic                wrap
);

    logic [CNT_BITS-1:0] total;
    logic [CNT_BITS-1:0] last_pos;
    logic [CNT_BITS-1:0] next_pos;
    logic [CNT_BITS-1:0] sync_start;
    logic [CNT_BITS-1:0] sync_end;
    logic                at_last;

    assign total      = CNT_BITS'(axis_total(32'(res_len), 32'(front_len),
                                             32'(sync_len), 32'(back_len)));
    assign last_pos   = total - CNT_BITS'(1);
    assign at_last    = (count == last_pos);
    assign next_pos   = at_last ? '0 : count + CNT_BITS'(1);
    assign sync_start = res_len + front_len;
    assign sync_end   = sync_start + sync_len;

    // wrap is combinational so the next axis steps on the same edge.
    assign wrap = step & at_last;

    // Flags decode the next position so they change on the same edge as count.
    always_ff @(posedge pclk) begin
        if (reset) begin
            count <= last_pos;
            de    <= 1'b0;
            sync  <= 1'b0;
        end else if (step) begin
            count <= next_pos;
            de    <= (next_pos < res_len);
            sync  <= (next_pos >= sync_start) && (next_pos < sync_end);
        end
    end

endmodule

// File: rtl/vid_sync_gen.sv
// rtl/vid_sync_gen.sv - raster sync generator top; VSG_RASTER_IRQ_EN enables the line compare pulse
module vid_sync_gen
    import vid_timing_pkg::*;
#(
    parameter int PIX_CLK_DIV = PIX_CLK_DIV_DEFAULT,
    parameter int CNT_BITS    = 12,
    parameter int H_RES       = H_RES_DEFAULT,
    parameter int H_FRONT     = H_FRONT_DEFAULT,
    parameter int H_SYNC      = H_SYNC_DEFAULT,
    parameter int H_BACK      = H_BACK_DEFAULT,
    parameter int V_RES       = V_RES_DEFAULT,
    parameter int V_FRONT     = V_FRONT_DEFAULT,
    parameter int V_SYNC      = V_SYNC_DEFAULT,
    parameter int V_BACK      = V_BACK_DEFAULT
) (
    input  logic           pclk,
    input  logic           reset,
    vid_sync_gen_if.master vid
);

    localparam logic [3:0] PC_LAST = 4'(PIX_CLK_DIV - 1);

    logic [3:0]          pc_ena;
    logic                advance;
    logic [CNT_BITS-1:0] h_count;
    logic [CNT_BITS-1:0] v_count;
    logic                hde;
    logic                vde;
    logic                hs;
    logic                vs;
    logic                h_wrap;
    logic                v_wrap;
    logic                line_start;
    logic                frame_start;
    logic                raster_irq;

    // Positions advance on the last phase so they hold for a whole pixel from phase 0.
    assign advance = (pc_ena == PC_LAST);

    // Pixel phase counter; stays at 0 when the divider is 1.
    always_ff @(posedge pclk) begin
        if (reset) begin
            pc_ena <= 4'd0;
        end else if (advance) begin
            pc_ena <= 4'd0;
        end else begin
            pc_ena <= pc_ena + 4'd1;
        end
    end

    vsg_axis_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_h_axis (
        .pclk      (pclk),
        .reset     (reset),
        .step      (advance),
        .res_len   (CNT_BITS'(H_RES)),
        .front_len (CNT_BITS'(H_FRONT)),
        .sync_len  (CNT_BITS'(H_SYNC)),
        .back_len  (CNT_BITS'(H_BACK)),
        .count     (h_count),
        .de        (hde),
        .sync      (hs),
        .wrap      (h_wrap)
    );

    vsg_axis_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_v_axis (
        .pclk      (pclk),
        .reset     (reset),
        .step      (h_wrap),
        .res_len   (CNT_BITS'(V_RES)),
        .front_len (CNT_BITS'(V_FRONT)),
        .sync_len  (CNT_BITS'(V_SYNC)),
        .back_len  (CNT_BITS'(V_BACK)),
        .count     (v_count),
        .de        (vde),
        .sync      (vs),
        .wrap      (v_wrap)
    );

    // Strobes register the wrap events, landing on the phase-0 cycle of the new position.
    always_ff @(posedge pclk) begin
        if (reset) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= h_wrap;
            frame_start <= h_wrap & v_wrap;
        end
    end

`ifdef VSG_RASTER_IRQ_EN
    logic [CNT_BITS-1:0] next_v;

    assign next_v = v_wrap ? '0 : v_count + CNT_BITS'(1);

    // Compare the line being entered against raster_line, sampled on the line wrap edge.
    always_ff @(posedge pclk) begin
        if (reset) begin
            raster_irq <= 1'b0;
        end else begin
            raster_irq <= h_wrap && (next_v == vid.raster_line);
        end
    end
`else
    logic unused_raster_line;

    assign unused_raster_line = ^vid.raster_line;
    assign raster_irq         = 1'b0;
`endif

    assign vid.pc_ena      = pc_ena;
    assign vid.h_count     = h_count;
    assign vid.v_count     = v_count;
    assign vid.hde         = hde;
    assign vid.vde         = vde;
    assign vid.hs          = hs;
    assign vid.vs          = vs;
    assign vid.line_start  = line_start;
    assign vid.frame_start = frame_start;
    assign vid.raster_irq  = raster_irq;

endmodule

// File: doc/vid_sync_gen.md
Name: vid_sync_gen

Overview:
Raster timing generator that sits directly upstream of the video output stencil stage. It divides pclk into pixel phases (pc_ena) and runs horizontal and vertical position counters. It produces the hde/vde/hs/vs timing set that the downstream pixel pipe consumes, plus position and line/frame strobes for the pixel-fetch logic. Syncs are produced active-high; polarity inversion happens downstream.

Parameters:
PIX_CLK_DIV, 4, pclk cycles per pixel; legal range 1..16; pc_ena counts 0..PIX_CLK_DIV-1
CNT_BITS, 12, width of h_count and v_count
H_RES, 640, active pixels per line
H_FRONT, 16, horizontal front porch in pixels
H_SYNC, 96, horizontal sync width in pixels
H_BACK, 48, horizontal back porch in pixels; must be >=1
V_RES, 480, active lines per frame
V_FRONT, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BACK, 33, vertical back porch in lines; must be >=1

Ports:
pclk  in  1  pixel-pipe clock
reset  in  1  synchronous, active-high
pc_ena  out  4  pixel phase counter; pixel strobe is pc_ena==0
h_count  out  CNT_BITS  horizontal position of the current pixel
v_count  out  CNT_BITS  vertical position of the current line
hde  out  1  high while h_count<H_RES
vde  out  1  high while v_count<V_RES
hs  out  1  high while H_RES+H_FRONT <= h_count < H_RES+H_FRONT+H_SYNC
vs  out  1  high while V_RES+V_FRONT <= v_count < V_RES+V_FRONT+V_SYNC
line_start  out  1  one-pclk pulse, concurrent with pc_ena==0, when h_count==0
frame_start  out  1  one-pclk pulse, concurrent with pc_ena==0, when h_count==0 and v_count==0
raster_line  in  CNT_BITS  line compare value (optional feature)
raster_irq  out  1  line compare pulse (optional feature)

Behaviour:
- Definitions: H_TOTAL = H_RES+H_FRONT+H_SYNC+H_BACK (default 800). V_TOTAL = V_RES+V_FRONT+V_SYNC+V_BACK (default 525).
- pc_ena: increments every pclk and wraps from PIX_CLK_DIV-1 to 0. With PIX_CLK_DIV=1 it is constantly 0.
- Advance event: the pclk edge on which pc_ena==PIX_CLK_DIV-1. On that edge h_count, v_count, hde, vde, hs, vs all update together from the next position. All are stable for the entire following pixel period, including the pc_ena==0 cycle.
- h_count wraps H_TOTAL-1 -> 0. v_count increments only on that wrap, and itself wraps V_TOTAL-1 -> 0.
- All outputs are registered. Decode uses the next-position values, so there is zero skew between counts and timing flags.
- line_start and frame_start are asserted for exactly one pclk: the cycle where pc_ena==0 and the qualifying position is held.
- Reset: pc_ena=0, h_count=H_TOTAL-1, v_count=V_TOTAL-1, hde=vde=hs=vs=0, line_start=frame_start=raster_irq=0.
- First pixel after reset: the first advance occurs on the (PIX_CLK_DIV)th pclk after reset deassertion and moves to (0,0). frame_start and line_start then fire.
- Reset asserted mid-frame restarts immediately to the reset state on the next edge. No partial-line completion.
- Arithmetic: all compares are unsigned, CNT_BITS wide. Parameters satisfy H_TOTAL, V_TOTAL < 2^CNT_BITS. The sync window end is exclusive.

Optional Feature:
- Macro: VSG_RASTER_IRQ_EN.
- Defined: raster_irq pulses for one pclk, coincident with line_start, when the new v_count equals raster_line. raster_line is sampled on the advance edge that wraps h_count to 0. A raster_line >= V_TOTAL never fires.
- Undefined: raster_line is ignored and raster_irq is tied 0. Port list is unchanged.

Decomposition:
- Shared package vid_timing_pkg: default 640x480@60 timing constants (the H_*/V_* values above), a derived-totals function, and a localparam for default PIX_CLK_DIV=4.
- One sub-module, vsg_axis_counter, instantiated twice (horizontal, vertical).
  - Inputs: step enable, RES, FRONT, SYNC, BACK.
  - Outputs: count, de, sync, wrap.
  - Horizontal wrap drives the vertical step enable.

Test Plan:
- Reset release, defaults -> first frame_start pulse 4 pclk after release at (0,0); hde=vde=1; pc_ena sequence 0,1,2,3,0.
- Free run one line -> hde high 640 pixels (2560 pclk); hs rises at h_count=656 and falls at h_count=752; line period 3200 pclk.
- Free run full frame -> vs high for v_count 490..491; vde low from line 480; frame_start period 1,680,000 pclk.
- PIX_CLK_DIV=1 -> pc_ena constant 0; counts advance every pclk; line period 800 pclk.
- Reset asserted at h=300, v=200 -> next edge shows reset values; restart timing identical to the first scenario.
- VSG_RASTER_IRQ_EN defined, raster_line=100 -> single raster_irq pulse per frame, concurrent with line_start at v_count=100; raster_line=600 -> no pulse.
